// File: rtl/data_memory_block.sv
// data_memory_block: block-granular backing store below the data cache.
// Serves whole-block reads (line fills) and writes (write-backs) after a fixed
// number of wait cycles, holding mem_busywait high until the access is done.
//
// Handshake: the requester raises mem_read and/or mem_write and holds it,
// together with its address/data, while mem_busywait is high. The request is
// sampled once on the first rising edge in IDLE. busywait falls for exactly
// one cycle (DONE), which is when mem_readdata is valid. A request still held
// during DONE is only taken on the following IDLE cycle.
module data_memory_block #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                op_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_array [2**ADDR_W];

  // busywait follows the request combinationally in IDLE so the cache stalls
  // in the same cycle it asks; it is forced high in BUSY and low in DONE.
  always_comb begin
    mem_busywait = 1'b0;
    case (state)
      IDLE:    mem_busywait = mem_read | mem_write;
      BUSY:    mem_busywait = 1'b1;
      DONE:    mem_busywait = 1'b0;
      default: mem_busywait = 1'b0;
    endcase
  end

  assign dbg_state = state;

  // Array write strobe: last BUSY edge of a latched write, suppressed by reset.
  always_comb begin
    mem_we = reset && (state == BUSY) && (count == '0) && op_write_q;
  end

  // Access FSM: latch the request, count down the latency, then complete.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read | mem_write) begin
            // A combined read+write is a write; the read half is dropped.
            op_write_q <= mem_write;
            addr_q     <= mem_address;
            wdata_q    <= mem_writedata;
            count      <= CNT_W'(LATENCY - 1);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            if (!op_write_q) begin
              mem_readdata <= mem_array[addr_q];
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset: contents survive a reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_block.sv
// Bench for data_memory_block: default build plus a LATENCY=1 build sharing
// the same request inputs.
module tb_data_memory_block;

  localparam int LAT   = 5;
  localparam int BUSYN = LAT + 1;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [5:0]  mem_address = '0;
  logic [31:0] mem_writedata = '0;

  logic [31:0] rdata0, rdata1;
  logic        busy0, busy1;
  logic [1:0]  st0, st1;

  data_memory_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(rdata0), .mem_busywait(busy0), .dbg_state(st0)
  );

  data_memory_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(rdata1), .mem_busywait(busy1), .dbg_state(st1)
  );

  // ---------------- scoreboard / reference ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rd;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: writes update the array; reads return the array and are
  // the only thing that changes the returned-data register.
  task automatic ref_access(input logic rd, input logic wr, input logic [5:0] a,
                            input logic [31:0] d);
    if (wr) ref_mem[a] = d;
    else if (rd) ref_rd = ref_mem[a];
    exp_q.push_back(ref_rd);
  endtask

  // ---------------- driver ----------------
  // mode 0: plain; 1: scramble address/data/op mid-BUSY; 2: drop request mid-BUSY
  task automatic do_access(input logic rd, input logic wr, input logic [5:0] a,
                           input logic [31:0] d, input int mode,
                           output int busy_n, output logic [31:0] rdata_done);
    int guard;
    @(negedge clock);
    mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
    busy_n = 0;
    guard  = 0;
    #1;
    while (busy0 && guard < 40) begin
      busy_n++;
      @(negedge clock);
      guard++;
      if (guard == 2 && mode == 1) begin
        mem_address = ~a; mem_writedata = ~d; mem_write = ~wr;
      end
      if (guard == 2 && mode == 2) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (guard >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: busywait still high after %0d cycles, required low", guard);
    end
    rdata_done = rdata0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_checked(input string tag, input logic rd, input logic wr,
                             input logic [5:0] a, input logic [31:0] d, input int mode);
    int          bn;
    logic [31:0] rdv;
    logic [31:0] exp_rd;
    ref_access(rd, wr, a, d);
    do_access(rd, wr, a, d, mode, bn, rdv);
    exp_rd = exp_q.pop_front();
    check({tag, "_busy"}, 64'(bn), 64'(BUSYN));
    check({tag, "_rdata"}, 64'(rdv), 64'(exp_rd));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          bn;
    logic [31:0] rdv;
    logic [5:0]  ra;
    logic [31:0] rdat;
    logic        rr, rw;

    vecs[0] = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 32'h0,        BUSYN};
    vecs[1] = '{1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF, BUSYN};
    vecs[2] = '{1'b0, 1'b1, 6'd0,  32'h11223344, 32'hDEADBEEF, BUSYN};
    vecs[3] = '{1'b0, 1'b1, 6'd63, 32'hA5A5A5A5, 32'hDEADBEEF, BUSYN};
    vecs[4] = '{1'b1, 1'b0, 6'd0,  32'h0,        32'h11223344, BUSYN};
    vecs[5] = '{1'b1, 1'b0, 6'd63, 32'h0,        32'hA5A5A5A5, BUSYN};
    vecs[6] = '{1'b1, 1'b1, 6'd3,  32'hCAFEF00D, 32'hA5A5A5A5, BUSYN};
    vecs[7] = '{1'b1, 1'b0, 6'd3,  32'h0,        32'hCAFEF00D, BUSYN};
    vecs[8] = '{1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF, BUSYN};

    // reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 64'(busy0), 64'(0));
    check("rst_rdata", 64'(rdata0), 64'(0));
    check("rst_state", 64'(st0), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    // LATENCY=1 build: 2-cycle busywait and no acceptance during DONE
    repeat (2) @(negedge clock);
    mem_write = 1'b1; mem_address = 6'd20; mem_writedata = 32'h600DF00D;
    #1 check("l1_w_busy_req", 64'(busy1), 64'(1));
    @(negedge clock);
    check("l1_w_busy_e0", 64'(busy1), 64'(1));
    check("l1_w_state_busy", 64'(st1), 64'(1));
    @(negedge clock);
    check("l1_w_busy_done", 64'(busy1), 64'(0));
    check("l1_w_state_done", 64'(st1), 64'(2));
    mem_write = 1'b0;
    @(negedge clock);
    check("l1_idle", 64'(st1), 64'(0));
    mem_read = 1'b1;
    #1 check("l1_r_busy_req", 64'(busy1), 64'(1));
    @(negedge clock);
    check("l1_r_state_busy", 64'(st1), 64'(1));
    @(negedge clock);
    check("l1_r_busy_done", 64'(busy1), 64'(0));
    check("l1_r_rdata", 64'(rdata1), 64'(32'h600DF00D));
    @(negedge clock);
    check("l1_held_idle", 64'(st1), 64'(0));
    check("l1_held_busy", 64'(busy1), 64'(1));
    @(negedge clock);
    check("l1_held_accept", 64'(st1), 64'(1));
    mem_read = 1'b0;
    repeat (12) @(negedge clock);

    // fresh reset of both builds before the default-latency checks
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ref_rd = 32'h0;

    // directed table
    foreach (vecs[i]) begin
      ref_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, bn, rdv);
      check($sformatf("vec%0d_busy", i), 64'(bn), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d_rdata", i), 64'(rdv), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_ref", i), 64'(rdv), 64'(exp_q.pop_front()));
    end

    // reset in the middle of a write to block 9
    run_checked("pre9", 1'b0, 1'b1, 6'd9, 32'h0, 0);
    @(negedge clock);
    mem_write = 1'b1; mem_address = 6'd9; mem_writedata = 32'h12345678;
    repeat (3) @(negedge clock);
    check("midrst_state_busy", 64'(st0), 64'(1));
    reset = 1'b0; mem_write = 1'b0;
    #1;
    check("midrst_busy", 64'(busy0), 64'(0));
    check("midrst_rdata", 64'(rdata0), 64'(0));
    check("midrst_state", 64'(st0), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    ref_rd = 32'h0;
    run_checked("post_rst_rd9", 1'b1, 1'b0, 6'd9, 32'h0, 0);

    // address change during BUSY is ignored
    run_checked("w7", 1'b0, 1'b1, 6'd7, 32'h77777777, 0);
    run_checked("w8", 1'b0, 1'b1, 6'd8, 32'h88888888, 0);
    run_checked("rd7_scramble", 1'b1, 1'b0, 6'd7, 32'h0, 1);
    // request dropped mid-BUSY still completes
    run_checked("rd8_drop", 1'b1, 1'b0, 6'd8, 32'h0, 2);
    run_checked("w8_drop", 1'b0, 1'b1, 6'd8, 32'h8BADF00D, 2);
    run_checked("rd8_after", 1'b1, 1'b0, 6'd8, 32'h0, 0);

    // preload every block, then random traffic against the reference
    for (int a = 0; a < 64; a++) begin
      run_checked("preload", 1'b0, 1'b1, 6'(a), $urandom, 0);
    end
    for (int n = 0; n < 60; n++) begin
      ra   = 6'($urandom_range(0, 63));
      rdat = $urandom;
      rw   = ($urandom_range(0, 2) == 0);
      rr   = rw ? ($urandom_range(0, 3) == 0) : 1'b1;
      run_checked($sformatf("rand%0d", n), rr, rw, ra, rdat, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
